// File: rtl/core_v_mini_mcu_pkg.sv
// MCU-level constants needed by the interrupt router (external vector width).
package core_v_mini_mcu_pkg;

    localparam int NEXT_INT = 64;

endpackage

// File: rtl/ext_intr_router_pkg.sv
// Register map, mode encoding and counter width for ext_intr_router.
package ext_intr_router_pkg;

    localparam logic [7:0] ENABLE_OFFSET  = 8'h00;
    localparam logic [7:0] MODE_OFFSET    = 8'h04;
    localparam logic [7:0] PENDING_OFFSET = 8'h08;
    localparam logic [7:0] RAW_OFFSET     = 8'h0C;
    localparam logic [7:0] ROUTE_BASE     = 8'h10;
    localparam logic [7:0] CNT_BASE       = 8'h40;

    localparam int CNT_W = 8;

    typedef enum logic {
        INTR_LEVEL = 1'b0,
        INTR_EDGE  = 1'b1
    } intr_mode_e;

endpackage

// File: rtl/reg_pkg.sv
// Register-bus request/response types used by the peripheral config port.
// Matches the field layout of the shared register_interface package.
package reg_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

// File: rtl/ext_intr_router_src.sv
// Per-source interrupt capture: edge latch or level pass-through with W1C, plus
// optional saturating event counter when EXT_INTR_ROUTER_CNT_EN is defined.
module ext_intr_router_src
    import ext_intr_router_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             src_i,
    input  intr_mode_e       mode_i,
    input  logic             mode_arm_i,
    input  logic             w1c_i,
`ifdef EXT_INTR_ROUTER_CNT_EN
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] cnt_o,
`endif
    output logic             pending_o
);

    logic src_q;
    logic pending_q;
    logic pending_d;
    logic set_evt;

    // A set event is a fresh edge in edge mode, or pending rising in level mode.
    always_comb begin
        set_evt   = 1'b0;
        pending_d = pending_q;
        if (mode_i == INTR_EDGE) begin
            set_evt   = src_i & ~src_q;
            pending_d = set_evt | (pending_q & ~w1c_i);
        end else begin
            set_evt   = src_i & ~pending_q;
            pending_d = src_i;
        end
        // Switching level->edge starts from a clean slate.
        if (mode_arm_i) begin
            set_evt   = 1'b0;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            src_q     <= src_i;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

`ifdef EXT_INTR_ROUTER_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (cnt_clr_i) begin
            cnt_q <= '0;
        end else if (set_evt && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/ext_intr_router.sv
// External interrupt router: per-source capture, enable mask and programmable routing
// onto a registered NEXT_INT-wide vector; 1-cycle output latency. Optional macro EXT_INTR_ROUTER_CNT_EN.
module ext_intr_router
    import ext_intr_router_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int NEXT_INT  = core_v_mini_mcu_pkg::NEXT_INT,
    parameter int BASE_LINE = 2,
    parameter int ADDR_W    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  reg_pkg::reg_req_t     reg_req_i,
    output reg_pkg::reg_rsp_t     reg_rsp_o,
    input  logic [NUM_SRC-1:0]    src_i,
    output logic [NEXT_INT-1:0]   intr_vector_ext_o
);

    localparam int IDX_W = (NEXT_INT > 1) ? $clog2(NEXT_INT) : 1;

    logic [NUM_SRC-1:0]  enable_q;
    logic [NUM_SRC-1:0]  mode_q;
    logic [IDX_W-1:0]    route_q [NUM_SRC];
    logic [NEXT_INT-1:0] intr_q;
    logic [NEXT_INT-1:0] intr_d;
    logic [NUM_SRC-1:0]  pending;

    logic                en_we;
    logic                mode_we;
    logic [NUM_SRC-1:0]  mode_arm;
    logic [NUM_SRC-1:0]  pend_w1c;
    logic [NUM_SRC-1:0]  route_we;
    logic [31:0]         rdata;
    logic                err;
    logic [7:0]          off;

`ifdef EXT_INTR_ROUTER_CNT_EN
    logic [CNT_W-1:0]    cnt [NUM_SRC];
    logic [NUM_SRC-1:0]  cnt_clr;
`endif

    logic unused_req;
    assign unused_req = ^{reg_req_i.wstrb, reg_req_i.addr[ADDR_W-1:8]};

    assign off = reg_req_i.addr[7:0];

    always_comb begin
        rdata    = '0;
        err      = 1'b0;
        en_we    = 1'b0;
        mode_we  = 1'b0;
        pend_w1c = '0;
        route_we = '0;
`ifdef EXT_INTR_ROUTER_CNT_EN
        cnt_clr  = '0;
`endif
        if (reg_req_i.valid) begin
            if (off[1:0] != 2'b00) begin
                err = 1'b1;
            end else begin
                case (off)
                    ENABLE_OFFSET: begin
                        rdata = 32'(enable_q);
                        en_we = reg_req_i.write;
                    end
                    MODE_OFFSET: begin
                        rdata   = 32'(mode_q);
                        mode_we = reg_req_i.write;
                    end
                    PENDING_OFFSET: begin
                        rdata = 32'(pending);
                        if (reg_req_i.write) pend_w1c = reg_req_i.wdata[NUM_SRC-1:0];
                    end
                    RAW_OFFSET: begin
                        rdata = 32'(src_i);
                    end
                    default: begin
                        err = 1'b1;
                        for (int i = 0; i < NUM_SRC; i++) begin
                            if (off == 8'(ROUTE_BASE + 4 * i)) begin
                                err   = 1'b0;
                                rdata = 32'(route_q[i]);
                                if (reg_req_i.write) begin
                                    // Out-of-range line numbers are rejected, keeping the old route.
                                    if (reg_req_i.wdata >= 32'(NEXT_INT)) err = 1'b1;
                                    else route_we[i] = 1'b1;
                                end
                            end
`ifdef EXT_INTR_ROUTER_CNT_EN
                            if (off == 8'(CNT_BASE + 4 * i)) begin
                                err        = 1'b0;
                                rdata      = 32'(cnt[i]);
                                cnt_clr[i] = reg_req_i.write;
                            end
`endif
                        end
                        if (err) rdata = '0;
                    end
                endcase
            end
        end
    end

    // Response stays quiet while reset is asserted, even mid-transfer.
    assign reg_rsp_o.rdata = rst_ni ? rdata : '0;
    assign reg_rsp_o.error = rst_ni & err;
    assign reg_rsp_o.ready = 1'b1;

    assign mode_arm = {NUM_SRC{mode_we}} & reg_req_i.wdata[NUM_SRC-1:0] & ~mode_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enable_q <= '0;
            mode_q   <= '1;
            for (int i = 0; i < NUM_SRC; i++) route_q[i] <= IDX_W'(BASE_LINE + i);
        end else begin
            if (en_we)   enable_q <= reg_req_i.wdata[NUM_SRC-1:0];
            if (mode_we) mode_q   <= reg_req_i.wdata[NUM_SRC-1:0];
            for (int i = 0; i < NUM_SRC; i++) begin
                if (route_we[i]) route_q[i] <= reg_req_i.wdata[IDX_W-1:0];
            end
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        ext_intr_router_src u_src (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .src_i      (src_i[g]),
            .mode_i     (intr_mode_e'(mode_q[g])),
            .mode_arm_i (mode_arm[g]),
            .w1c_i      (pend_w1c[g]),
`ifdef EXT_INTR_ROUTER_CNT_EN
            .cnt_clr_i  (cnt_clr[g]),
            .cnt_o      (cnt[g]),
`endif
            .pending_o  (pending[g])
        );
    end

    always_comb begin
        intr_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending[i] && enable_q[i]) intr_d[route_q[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) intr_q <= '0;
        else         intr_q <= intr_d;
    end

    assign intr_vector_ext_o = intr_q;

endmodule

// File: tb/tb_ext_intr_router.sv
// Directed self-checking bench for ext_intr_router (NUM_SRC=4, NEXT_INT=64, BASE_LINE=2).
module tb_ext_intr_router;

    logic              clk_i;
    logic              rst_ni;
    reg_pkg::reg_req_t req;
    reg_pkg::reg_rsp_t rsp;
    logic [3:0]        src;
    logic [63:0]       intr;

    int n_cmp  = 0;
    int n_fail = 0;

    ext_intr_router #(
        .NUM_SRC   (4),
        .NEXT_INT  (64),
        .BASE_LINE (2),
        .ADDR_W    (32)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .reg_req_i         (req),
        .reg_rsp_o         (rsp),
        .src_i             (src),
        .intr_vector_ext_o (intr)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output logic e);
        req.valid = 1'b1; req.write = 1'b1; req.addr = a; req.wdata = d; req.wstrb = 4'hF;
        #1;
        e = rsp.error;
        @(posedge clk_i); #1;
        req.valid = 1'b0; req.write = 1'b0; req.wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic e);
        req.valid = 1'b1; req.write = 1'b0; req.addr = a; req.wdata = '0; req.wstrb = 4'hF;
        #1;
        d = rsp.rdata;
        e = rsp.error;
        @(posedge clk_i); #1;
        req.valid = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk_i); #1;
    endtask

    task automatic pulse(input int i);
        src[i] = 1'b1;
        cycle();
        src[i] = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        rst_ni = 1'b0;
        src = '0;
        req = '0;
        req.valid = 1'b1; req.addr = 32'hFC;
        #3;
        n_cmp++; if (rsp.error !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_error: got %b expected 0", rsp.error); end
        n_cmp++; if (rsp.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp.rdata); end
        req.valid = 1'b0;
        repeat (3) @(posedge clk_i);
        #2 rst_ni = 1'b1;
        cycle();
        n_cmp++; if (intr !== 64'h0) begin n_fail++; $display("FAIL reset_intr: got %h expected 0", intr); end
        bus_read(32'h00, d, e);
        n_cmp++; if (d !== 32'h0 || e !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %h err %b expected 0 err 0", d, e); end
        bus_read(32'h04, d, e);
        n_cmp++; if (d !== 32'hF) begin n_fail++; $display("FAIL reset_mode: got %h expected f", d); end
        bus_read(32'h14, d, e);
        n_cmp++; if (d !== 32'h3) begin n_fail++; $display("FAIL reset_route1: got %h expected 3", d); end
        bus_read(32'h1C, d, e);
        n_cmp++; if (d !== 32'h5) begin n_fail++; $display("FAIL reset_route3: got %h expected 5", d); end
        bus_read(32'h08, d, e);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h expected 0", d); end
    endtask

    task automatic test_edge();
        logic [31:0] d; logic e;
        bus_write(32'h00, 32'h1, e);
        pulse(0);
        n_cmp++; if (intr !== 64'h0) begin n_fail++; $display("FAIL edge_latency0: got %h expected 0", intr); end
        cycle();
        n_cmp++; if (intr !== 64'h4) begin n_fail++; $display("FAIL edge_line2: got %h expected 4", intr); end
        bus_read(32'h08, d, e);
        n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL edge_pending: got %h expected 1", d); end
        bus_read(32'h0C, d, e);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL edge_raw: got %h expected 0", d); end
        bus_write(32'h08, 32'h1, e);
        n_cmp++; if (intr !== 64'h4) begin n_fail++; $display("FAIL edge_w1c_hold: got %h expected 4", intr); end
        cycle();
        n_cmp++; if (intr !== 64'h0) begin n_fail++; $display("FAIL edge_w1c_clear: got %h expected 0", intr); end
    endtask

    task automatic test_level();
        logic [31:0] d; logic e;
        bus_write(32'h04, 32'hD, e);
        bus_write(32'h00, 32'h3, e);
        src[1] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            n_cmp++;
            if (intr !== ((k >= 2) ? 64'h8 : 64'h0)) begin
                n_fail++; $display("FAIL level_hold_%0d: got %h expected %h", k, intr, (k >= 2) ? 64'h8 : 64'h0);
            end
        end
        src[1] = 1'b0;
        cycle();
        n_cmp++; if (intr !== 64'h8) begin n_fail++; $display("FAIL level_tail: got %h expected 8", intr); end
        cycle();
        n_cmp++; if (intr !== 64'h0) begin n_fail++; $display("FAIL level_drop: got %h expected 0", intr); end
        src[1] = 1'b1;
        cycle();
        bus_write(32'h08, 32'h2, e);
        bus_read(32'h08, d, e);
        n_cmp++; if (d !== 32'h2) begin n_fail++; $display("FAIL level_w1c_ignored: got %h expected 2", d); end
        bus_write(32'h04, 32'hF, e);
        bus_read(32'h08, d, e);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL mode_arm_clear: got %h expected 0", d); end
        src[1] = 1'b0;
        cycle(); cycle();
    endtask

    task automatic test_route();
        logic [31:0] d; logic e;
        bus_write(32'h00, 32'h5, e);
        bus_write(32'h10, 32'd10, e);
        bus_write(32'h18, 32'd10, e);
        pulse(0);
        cycle();
        n_cmp++; if (intr !== 64'h400) begin n_fail++; $display("FAIL route_src0: got %h expected 400", intr); end
        pulse(2);
        bus_write(32'h08, 32'h1, e);
        cycle(); cycle();
        n_cmp++; if (intr !== 64'h400) begin n_fail++; $display("FAIL route_or_hold: got %h expected 400", intr); end
        bus_write(32'h08, 32'h4, e);
        cycle(); cycle();
        n_cmp++; if (intr !== 64'h0) begin n_fail++; $display("FAIL route_both_clear: got %h expected 0", intr); end
        bus_write(32'h10, 32'd70, e);
        n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL route_bad_err: got %b expected 1", e); end
        bus_read(32'h10, d, e);
        n_cmp++; if (d !== 32'd10) begin n_fail++; $display("FAIL route_bad_keep: got %0d expected 10", d); end
    endtask

    task automatic test_collision();
        logic [31:0] d; logic e;
        src[0] = 1'b1;
        bus_write(32'h08, 32'h1, e);
        src[0] = 1'b0;
        bus_read(32'h08, d, e);
        n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL collision_set_wins: got %h expected 1", d); end
        bus_write(32'h08, 32'h1, e);
        bus_read(32'hFC, d, e);
        n_cmp++; if (e !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h err %b expected 0 err 1", d, e); end
        bus_write(32'h00, 32'hF, e);
        bus_write(32'hFC, 32'h0, e);
        n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL unmapped_write_err: got %b expected 1", e); end
        bus_read(32'h00, d, e);
        n_cmp++; if (d !== 32'hF) begin n_fail++; $display("FAIL unmapped_write_effect: got %h expected f", d); end
    endtask

    task automatic test_counter();
        logic [31:0] d; logic e;
`ifdef EXT_INTR_ROUTER_CNT_EN
        for (int k = 0; k < 3; k++) begin pulse(3); cycle(); end
        bus_read(32'h4C, d, e);
        n_cmp++; if (d !== 32'h3 || e !== 1'b0) begin n_fail++; $display("FAIL cnt_three: got %h err %b expected 3 err 0", d, e); end
        for (int k = 0; k < 300; k++) begin pulse(3); cycle(); end
        bus_read(32'h4C, d, e);
        n_cmp++; if (d !== 32'hFF) begin n_fail++; $display("FAIL cnt_saturate: got %h expected ff", d); end
        bus_write(32'h4C, 32'h0, e);
        bus_read(32'h4C, d, e);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL cnt_clear: got %h expected 0", d); end
`else
        bus_read(32'h4C, d, e);
        n_cmp++; if (e !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL cnt_unmapped: got %h err %b expected 0 err 1", d, e); end
`endif
    endtask

    initial begin
        test_reset();
        test_edge();
        test_level();
        test_route();
        test_collision();
        test_counter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
